pulse_meter: RTL and testbench
==============================

# pulse_meter

Measures the waveform on a single-bit `signal` line, typically the output of the pulse generator stage, in cycles of `clock`. For each full high-then-low period, bounded by two rising edges, it reports the high width, the low width and the period. Results are held under a valid/ack handshake so a monitor or bench can read them. It is the consumer stage directly downstream of the pulse generator.

## Interface
- `WIDTH`, default 8: width of the high and low width counters and results.
- `clock`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high; sampled on the rising edge of `clock`.
- `signal`  in  1: measured waveform; may be asynchronous to `clock`.
- `ack`  in  1: consumer accepts the current result; sampled on the rising edge of `clock`.
- `high_width`  out  WIDTH: cycles `signal` was high in the last complete period.
- `low_width`  out  WIDTH: cycles `signal` was low in the last complete period.
- `period`  out  WIDTH+1: `high_width + low_width`, computed without truncation.
- `valid`  out  1: result registers hold an unaccepted measurement.
- `overflow`  out  1: a counter saturated during the reported period.
- `missed`  out  1: sticky; a result was overwritten before it was acked.

## Operation
- Synchronizer: three flops `s1 <= signal`, `s2 <= s1`, `s3 <= s2`.
  - `rise = s2 & ~s3`; `fall = ~s2 & s3`.
  - All logic below uses `s2` and the detected edges only.
- FSM states: WAIT, ARM, HIGH, LOW.
  - WAIT: go to ARM when `s2 == 0`. This blocks a false rise if `signal` is already high when reset releases.
  - ARM: on `rise`, `hcnt <= 1`, `sat <= 0`, go to HIGH.
  - HIGH: on `fall`, `lcnt <= 1` and go to LOW. Otherwise `hcnt` increments, saturating at 2^WIDTH-1; set `sat` if an increment is attempted at max.
  - LOW: on `rise`, publish the result (below), then `hcnt <= 1`, `sat <= 0`, go to HIGH. Otherwise `lcnt` increments with the same saturation and `sat` rule.
- Publish:
  - `high_width <= hcnt`; `low_width <= lcnt`; `period <= hcnt + lcnt` at WIDTH+1 bits.
  - `overflow <= sat`; `valid <= 1`.
- Handshake:
  - `valid` stays 1 until a cycle with `ack == 1`; then `valid <= 0`.
  - Outputs are stable while `valid` is 1 unless a new publish occurs.
  - Publish while `valid == 1` and `ack == 0`: overwrite the result and set `missed <= 1`. `missed` clears only on reset.
  - Publish and `ack == 1` in the same cycle: load the new result, `valid` stays 1, `missed` unchanged.
  - `ack` while `valid == 0` is ignored.
- Width rule: a high or low phase of N synchronized cycles reports N, for N from 1 to 2^WIDTH-1. Longer phases report 2^WIDTH-1 with `overflow = 1`.
- The first partial period after reset, from reset release to the first rise, is never reported.

## Timing
- Reset values:
  - `high_width`, `low_width`, `period`: 0.
  - `valid`, `overflow`, `missed`: 0.
  - `s1`, `s2`, `s3`: 0; state WAIT; `hcnt`, `lcnt`, `sat`: 0.
- Reset asserted mid-measurement wins over every other event in that cycle. The partial period is discarded and the FSM restarts at WAIT.
- Edge latency: if `signal` changes before clock edge n, then `s2` changes at edge n+1 and the FSM acts at edge n+2.
- `valid` rises at the edge after the rising edge that closes the period, which is the third clock edge after `signal` rises.
- `valid` falls at the edge where `ack == 1` is sampled; no combinational path from `ack` to any output.
- All outputs are registered.
- Throughput: one result per period; minimum measurable period is 2 cycles (1 high, 1 low).

## Test plan
- Reset and idle: hold `reset` for 3 cycles with `signal = 0` -> all outputs 0; `valid` stays 0 with no edges.
- Square wave: `signal` driven synchronously, 4 cycles high and 4 low, repeated; ack each result. From the second rise onward, `high_width = 4`, `low_width = 4`, `period = 8`, `overflow = 0`.
- Asymmetric and minimum pulses:
  - 3 high / 5 low -> 3/5/8.
  - 1 high / 1 low -> 1/1/2, one result every 2 cycles.
- Saturation: WIDTH = 8, 300 cycles high then 10 low, then a rise -> `high_width = 255`, `low_width = 10`, `period = 265`, `overflow = 1`. The next normal period reports `overflow = 0`.
- Handshake:
  - Withhold `ack` across two publishes -> second result visible, `missed = 1`.
  - Assert `ack` exactly on a publish cycle -> `valid` stays 1 and `missed` unchanged.
- Reset mid-pulse and high at reset: assert `reset` during HIGH with `signal` held high -> no result until `signal` goes low and rises again; the first report covers only a full period.

Source files
------------

// File: rtl/pulse_meter.sv
// pulse_meter: measures high width, low width and period of a single-bit
// waveform in clock cycles and holds each result under a valid/ack handshake.
module pulse_meter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             signal,
  input  logic             ack,
  output logic [WIDTH-1:0] high_width,
  output logic [WIDTH-1:0] low_width,
  output logic [WIDTH:0]   period,
  output logic             valid,
  output logic             overflow,
  output logic             missed
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CMAX = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic s1, s2, s3;
  logic rise, fall;
  logic [1:0] fill;
  logic primed;

  state_t state, state_nx;
  logic start_h, start_l, inc_h, inc_l, publish;

  logic [WIDTH-1:0] hcnt, lcnt;
  logic sat;

  // Three-flop synchronizer; s3 is only a delayed copy for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= signal;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // The synchronizer restarts at zero, so s2 only reflects signal two edges
  // after reset. Until then a zero in s2 is the reset value, not a real low,
  // and trusting it would arm on a line that was already high at release.
  always_ff @(posedge clock) begin
    if (reset)              fill <= 2'd0;
    else if (fill != 2'd2)  fill <= fill + 2'd1;
  end

  assign primed = (fill == 2'd2);

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= ST_WAIT;
    else       state <= state_nx;
  end

  // Next state and datapath strobes.
  always_comb begin
    state_nx = state;
    start_h  = 1'b0;
    start_l  = 1'b0;
    inc_h    = 1'b0;
    inc_l    = 1'b0;
    publish  = 1'b0;
    case (state)
      ST_WAIT: begin
        if (primed && !s2) state_nx = ST_ARM;
      end
      ST_ARM: begin
        if (rise) begin
          start_h  = 1'b1;
          state_nx = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          start_l  = 1'b1;
          state_nx = ST_LOW;
        end else begin
          inc_h = 1'b1;
        end
      end
      ST_LOW: begin
        if (rise) begin
          publish  = 1'b1;
          start_h  = 1'b1;
          state_nx = ST_HIGH;
        end else begin
          inc_l = 1'b1;
        end
      end
      default: state_nx = ST_WAIT;
    endcase
  end

  // Phase counters; they stick at CMAX and flag sat for the whole period.
  always_ff @(posedge clock) begin
    if (reset) begin
      hcnt <= '0;
      lcnt <= '0;
      sat  <= 1'b0;
    end else begin
      if (start_h) begin
        hcnt <= ONE;
        sat  <= 1'b0;
      end else if (inc_h) begin
        if (hcnt == CMAX) sat  <= 1'b1;
        else              hcnt <= hcnt + ONE;
      end
      if (start_l) begin
        lcnt <= ONE;
      end else if (inc_l) begin
        if (lcnt == CMAX) sat  <= 1'b1;
        else              lcnt <= lcnt + ONE;
      end
    end
  end

  // Result registers and handshake; a new publish beats a same-cycle ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      high_width <= '0;
      low_width  <= '0;
      period     <= '0;
      overflow   <= 1'b0;
      valid      <= 1'b0;
      missed     <= 1'b0;
    end else if (publish) begin
      high_width <= hcnt;
      low_width  <= lcnt;
      period     <= {1'b0, hcnt} + {1'b0, lcnt};
      overflow   <= sat;
      valid      <= 1'b1;
      if (valid && !ack) missed <= 1'b1;
    end else if (ack) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: directed waveforms plus random segments, checked
// every cycle against a run-length reference model of the sampled signal.
module tb_pulse_meter;

  localparam int W   = 8;
  localparam int MAX = (1 << W) - 1;

  logic clock = 1'b0;
  logic reset, signal, ack;
  logic [W-1:0] high_width, low_width;
  logic [W:0]   period;
  logic valid, overflow, missed;

  pulse_meter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .signal(signal), .ack(ack),
    .high_width(high_width), .low_width(low_width), .period(period),
    .valid(valid), .overflow(overflow), .missed(missed)
  );

  always #5 clock = ~clock;

  int npass = 0;
  int ntot  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: works on the stream of signal values sampled at each
  // post-reset edge. A period is rise..fall..rise in that stream; the result
  // becomes visible two edges after the closing rise is sampled.
  typedef struct { int due; int h; int l; } pub_t;
  pub_t pq[$];
  int  cyc = 0;
  int  k = 0;
  bit  xprev = 1'b0;
  bit  have_rise = 1'b0, have_fall = 1'b0;
  int  last_rise = 0, last_fall = 0;
  int  m_h = 0, m_l = 0, m_p = 0;
  bit  m_valid = 1'b0, m_ov = 1'b0, m_missed = 1'b0;
  int  ack_pct = 100;

  task automatic model_step(input bit r, input bit x, input bit a);
    cyc++;
    if (r) begin
      k = 0; xprev = 1'b0; have_rise = 1'b0; have_fall = 1'b0;
      pq.delete();
      m_h = 0; m_l = 0; m_p = 0; m_valid = 1'b0; m_ov = 1'b0; m_missed = 1'b0;
      return;
    end
    if (pq.size() > 0 && pq[0].due == cyc) begin
      pub_t p;
      p = pq.pop_front();
      m_h  = (p.h > MAX) ? MAX : p.h;
      m_l  = (p.l > MAX) ? MAX : p.l;
      m_p  = m_h + m_l;
      m_ov = (p.h > MAX) || (p.l > MAX);
      if (m_valid && !a) m_missed = 1'b1;
      m_valid = 1'b1;
    end else if (a) begin
      m_valid = 1'b0;
    end
    k++;
    if (k >= 2 && !xprev && x) begin
      if (have_rise && have_fall)
        pq.push_back('{due: cyc + 2, h: last_fall - last_rise, l: k - last_fall});
      last_rise = k; have_rise = 1'b1; have_fall = 1'b0;
    end else if (have_rise && !have_fall && xprev && !x) begin
      last_fall = k; have_fall = 1'b1;
    end
    xprev = x;
  endtask

  task automatic cyc1(input bit r, input bit s, input bit a);
    reset = r; signal = s; ack = a;
    @(posedge clock);
    model_step(r, s, a);
    @(negedge clock);
    chk("valid",    32'(valid),      32'(m_valid));
    chk("missed",   32'(missed),     32'(m_missed));
    chk("high",     32'(high_width), 32'(m_h));
    chk("low",      32'(low_width),  32'(m_l));
    chk("period",   32'(period),     32'(m_p));
    chk("overflow", 32'(overflow),   32'(m_ov));
  endtask

  task automatic phase(input bit v, input int n);
    repeat (n) cyc1(1'b0, v, ($urandom_range(0, 99) < ack_pct));
  endtask

  task automatic do_reset(input bit v, input int n);
    repeat (n) cyc1(1'b1, v, 1'b0);
  endtask

  task automatic wave(input int h, input int l, input int reps);
    repeat (reps) begin
      phase(1'b1, h);
      phase(1'b0, l);
    end
  endtask

  initial begin
    reset = 1'b1; signal = 1'b0; ack = 1'b0;
    @(negedge clock);

    // Reset and idle
    do_reset(1'b0, 3);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_missed", 32'(missed), 0);
    phase(1'b0, 10);
    chk("idle_valid", 32'(valid), 0);

    // Square, asymmetric and minimum waveforms, ack always high so acks
    // coincide with publish cycles.
    ack_pct = 100;
    wave(4, 4, 5);
    chk("sq_high", 32'(high_width), 4);
    chk("sq_period", 32'(period), 8);
    chk("sq_nomiss", 32'(missed), 0);
    wave(3, 5, 4);
    chk("asym_low", 32'(low_width), 5);
    wave(1, 1, 8);
    chk("min_period", 32'(period), 2);

    // Saturation, then a normal period clears overflow
    phase(1'b1, 300);
    phase(1'b0, 10);
    phase(1'b1, 3);
    chk("sat_high", 32'(high_width), 255);
    chk("sat_low", 32'(low_width), 10);
    chk("sat_period", 32'(period), 265);
    chk("sat_ovf", 32'(overflow), 1);
    phase(1'b0, 5);
    phase(1'b1, 3);
    chk("post_high", 32'(high_width), 3);
    chk("post_low", 32'(low_width), 5);
    chk("post_ovf", 32'(overflow), 0);

    // Withheld ack across two publishes
    ack_pct = 0;
    phase(1'b0, 3); phase(1'b1, 2);
    phase(1'b0, 4); phase(1'b1, 3);
    chk("hs_missed", 32'(missed), 1);
    chk("hs_valid", 32'(valid), 1);
    chk("hs_high", 32'(high_width), 2);
    chk("hs_low", 32'(low_width), 4);

    // Reset during HIGH with signal held high across release
    phase(1'b1, 6);
    do_reset(1'b1, 3);
    phase(1'b1, 10);
    chk("rh_valid0", 32'(valid), 0);
    chk("rh_missed", 32'(missed), 0);
    phase(1'b0, 4); phase(1'b1, 5);
    chk("rh_valid1", 32'(valid), 0);
    phase(1'b0, 3); phase(1'b1, 3);
    chk("rh_valid2", 32'(valid), 1);
    chk("rh_high", 32'(high_width), 5);
    chk("rh_low", 32'(low_width), 3);

    // Random segments, random ack density, occasional reset
    for (int i = 0; i < 300; i++) begin
      int len;
      if ($urandom_range(0, 19) == 0) ack_pct = $urandom_range(0, 100);
      len = ($urandom_range(0, 29) == 0) ? $urandom_range(200, 300)
                                         : $urandom_range(1, 12);
      if ($urandom_range(0, 49) == 0) do_reset(1'(i), $urandom_range(1, 3));
      phase(1'(i), len);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
